// File: rtl/ahb_lite_req_master_pkg.sv
// Shared AHB-Lite encodings and FSM states for the request master.
package ahb_lite_req_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

endpackage

// File: rtl/ahb_lite_req_master_fifo.sv
// Small synchronous FIFO; occupancy is a registered count, so a pop
// only frees a slot for pushes on the following cycle.
module sync_fifo #(
  parameter int WIDTH = 58,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ahb_lite_req_master.sv
// Buffers word requests and issues them one at a time as AHB-Lite SINGLE
// transfers, returning one response per completed transfer.
module ahb_lite_req_master #(
  parameter int HADDR_BITS = 25,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [HADDR_BITS-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [HADDR_BITS-1:0] HADDR,
  output logic                  HWRITE,
  output logic [1:0]            HTRANS,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic                  HSEL,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);
  import ahb_lite_req_master_pkg::*;

  localparam int ENTRY_W = 1 + HADDR_BITS + 32;

  state_t                state, state_next;
  logic [ENTRY_W-1:0]    head;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [31:0]           wdata_q, wdata_next;
  logic [HADDR_BITS-1:0] haddr_next;
  logic                  hwrite_next, rsp_valid_next, rsp_write_next, rsp_err_next;
  logic [1:0]            htrans_next;
  logic [31:0]           hwdata_next, rsp_rdata_next;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .push   (req_valid && req_ready),
    .pop    (fifo_pop),
    .wdata  ({req_write, req_addr, req_wdata}),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign req_ready = !fifo_full;
  assign HSEL      = (HTRANS == HTRANS_NONSEQ);
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HTRANS    <= HTRANS_IDLE;
      HWDATA    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      HADDR     <= haddr_next;
      HWRITE    <= hwrite_next;
      HTRANS    <= htrans_next;
      HWDATA    <= hwdata_next;
      wdata_q   <= wdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_write <= rsp_write_next;
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (!fifo_empty) state_next = S_ADDR;
      S_ADDR: if (HREADY)      state_next = S_DATA;
      S_DATA: if (HREADY)      state_next = S_RESP;
      S_RESP: if (rsp_ready)   state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  // Next values of the registered AHB and response outputs.
  always_comb begin
    fifo_pop       = 1'b0;
    haddr_next     = HADDR;
    hwrite_next    = HWRITE;
    htrans_next    = HTRANS;
    hwdata_next    = HWDATA;
    wdata_next     = wdata_q;
    rsp_valid_next = rsp_valid;
    rsp_write_next = rsp_write;
    rsp_err_next   = rsp_err;
    rsp_rdata_next = rsp_rdata;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          hwrite_next = head[ENTRY_W-1];
          haddr_next  = head[ENTRY_W-2 -: HADDR_BITS];
          wdata_next  = head[31:0];
          htrans_next = HTRANS_NONSEQ;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          htrans_next = HTRANS_IDLE;
          hwdata_next = HWRITE ? wdata_q : 32'd0;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          rsp_valid_next = 1'b1;
          rsp_write_next = HWRITE;
          rsp_err_next   = HRESP;
          rsp_rdata_next = HWRITE ? 32'd0 : HRDATA;
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_req_master.sv
// Randomized scoreboard bench: a memory-backed AHB slave model plus an
// in-order reference of expected responses and bus transfers.
module tb_ahb_lite_req_master;

  localparam logic [24:0] ERR_BASE = 25'h1FF_0000;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        req_valid, req_ready, req_write;
  logic [24:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [24:0] HADDR;
  logic        HWRITE, HSEL, HREADY, HRESP;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA, HRDATA;

  always #5 HCLK = ~HCLK;

  ahb_lite_req_master #(.HADDR_BITS(25), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HSEL(HSEL), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct packed {logic w; logic err; logic [31:0] rdata;} rsp_t;
  typedef struct packed {logic [24:0] addr; logic w; logic [31:0] wdata;} bus_t;

  int   n_compared = 0;
  int   n_mismatched = 0;
  rsp_t rsp_q[$];
  bus_t bus_q[$];
  logic [31:0] ref_mem   [logic [24:0]];
  logic [31:0] slave_mem [logic [24:0]];
  int   addr_wait_cfg = 0;
  int   data_wait_cfg = 0;
  int   rsp_mode = 1;

  function automatic logic [31:0] dflt(input logic [24:0] a);
    return {7'h5A, a};
  endfunction

  function automatic int pick(input int cfg);
    return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic record_fail(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  // Reference: transfers complete in order, so the outcome of each request is
  // decided at the moment it is accepted.
  task automatic model_push(input logic w, input logic [24:0] a, input logic [31:0] d);
    rsp_t r;
    bus_t b;
    r.w     = w;
    r.err   = (a >= ERR_BASE);
    r.rdata = w ? 32'd0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
    if (w && !r.err) ref_mem[a] = d;
    b.addr = a; b.w = w; b.wdata = d;
    rsp_q.push_back(r);
    bus_q.push_back(b);
  endtask

  task automatic apply_stimulus(input logic w, input logic [24:0] a, input logic [31:0] d);
    int guard = 0;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && guard < 2000) begin
      @(negedge HCLK);
      guard++;
    end
    if (!req_ready) begin
      record_fail("req_accept_timeout");
      req_valid = 1'b0;
      return;
    end
    model_push(w, a, d);
    @(negedge HCLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && guard < 5000) begin
      @(negedge HCLK);
      guard++;
    end
    if (guard >= 5000) record_fail(name);
  endtask

  task automatic preload(input logic [24:0] a, input logic [31:0] v);
    slave_mem[a] = v;
    ref_mem[a]   = v;
  endtask

  // Response monitor: drives rsp_ready and scores each consumed response.
  initial begin
    rsp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge HCLK);
      if (HRESET) rsp_ready = 1'b0;
      else begin
        rsp_ready = (rsp_mode == 1) ? 1'b1 : (rsp_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        if (rsp_valid && rsp_ready) begin
          if (rsp_q.size() == 0) record_fail("unexpected_response");
          else begin
            e = rsp_q.pop_front();
            check_output("response", 64'({rsp_write, rsp_err, rsp_rdata}), 64'(e));
          end
        end
      end
    end
  end

  // AHB slave model; resolves the previous rising edge from values latched
  // at the prior falling edge, then drives HREADY/HRDATA/HRESP for the next.
  bit          dp_active, dp_write, aw_started, pv_nonseq, pv_hready, pv_hwrite;
  logic [24:0] dp_addr, pv_haddr;
  logic [31:0] dp_exp_wdata, pv_hwdata;
  logic [6:0]  pv_ctrl;
  int          dp_wait, aw_wait, aw_target, ns_cycles;

  initial begin
    bus_t b;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dp_active = 0; aw_started = 0; aw_wait = 0; ns_cycles = 0;
        pv_nonseq = 0; pv_hready = 1;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      end else begin
        if (pv_hready) begin
          if (dp_active) begin
            if (dp_write) begin
              check_output("hwdata", 64'(pv_hwdata), 64'(dp_exp_wdata));
              if (dp_addr < ERR_BASE) slave_mem[dp_addr] = pv_hwdata;
            end
            dp_active = 0;
          end
          if (pv_nonseq) begin
            if (bus_q.size() == 0) record_fail("unexpected_transfer");
            else begin
              b = bus_q.pop_front();
              check_output("haddr_hwrite", 64'({pv_haddr, pv_hwrite}), 64'({b.addr, b.w}));
              dp_exp_wdata = b.wdata;
            end
            check_output("nonseq_cycles", 64'(ns_cycles), 64'(aw_target + 1));
            check_output("hsize_hburst_hsel", 64'(pv_ctrl), 64'({3'b010, 3'b000, 1'b1}));
            dp_active = 1; dp_addr = pv_haddr; dp_write = pv_hwrite;
            dp_wait = pick(data_wait_cfg); aw_started = 0; ns_cycles = 0;
          end
        end else begin
          if (pv_nonseq)
            check_output("addr_phase_stable", 64'({HTRANS, HADDR, HWRITE}), 64'({2'b10, pv_haddr, pv_hwrite}));
          if (dp_active && dp_write)
            check_output("hwdata_stable", 64'(HWDATA), 64'(pv_hwdata));
        end
        if (HTRANS == 2'b10) begin
          if (!aw_started) begin
            aw_started = 1; aw_target = pick(addr_wait_cfg); aw_wait = aw_target;
          end
          ns_cycles++;
        end
        if (dp_active) begin
          if (dp_wait > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom; dp_wait--;
          end else begin
            HREADY = 1'b1;
            HRESP  = (dp_addr >= ERR_BASE);
            HRDATA = dp_write ? $urandom : (slave_mem.exists(dp_addr) ? slave_mem[dp_addr] : dflt(dp_addr));
          end
        end else if (HTRANS == 2'b10 && aw_wait > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; aw_wait--;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0;
        end
        pv_nonseq = (HTRANS == 2'b10); pv_hready = HREADY;
        pv_haddr = HADDR; pv_hwrite = HWRITE; pv_hwdata = HWDATA;
        pv_ctrl = {HSIZE, HBURST, HSEL};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int guard;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    check_output("reset_bus", 64'({HTRANS, HADDR, HWRITE, HSEL}), 64'(0));
    check_output("reset_data", 64'({HWDATA, rsp_rdata}), 64'(0));
    check_output("reset_flags", 64'({rsp_valid, rsp_write, rsp_err, req_ready}), 64'(4'b0001));

    $display("[TB] single write, zero-wait slave");
    apply_stimulus(1'b1, 25'h0000100, 32'hDEADBEEF);
    wait_drain("drain_write");

    $display("[TB] read with 6 data-phase wait states");
    preload(25'h0000100, 32'h12345678);
    data_wait_cfg = 6;
    apply_stimulus(1'b0, 25'h0000100, 32'h0);
    wait_drain("drain_stalled_read");
    data_wait_cfg = 0;

    $display("[TB] error response then normal write");
    apply_stimulus(1'b0, 25'h1FFFFFC, 32'h0);
    apply_stimulus(1'b1, 25'h0000180, 32'hCAFE0180);
    wait_drain("drain_error");

    $display("[TB] address phase held 3 extra cycles");
    addr_wait_cfg = 3;
    apply_stimulus(1'b1, 25'h0000200, 32'h0BADF00D);
    wait_drain("drain_addr_wait");
    addr_wait_cfg = 0;

    $display("[TB] fill FIFO under response backpressure");
    rsp_mode = 0;
    for (int i = 0; i < 5; i++)
      apply_stimulus(1'(i % 2), 25'h0000400 + 25'(i * 4), 32'hA000_0000 + 32'(i));
    repeat (3) @(negedge HCLK);
    check_output("fifo_full_ready_low", 64'(req_ready), 64'(0));
    check_output("rsp_held", 64'(rsp_valid), 64'(1));
    rsp_mode = 1;
    wait_drain("drain_backpressure");

    $display("[TB] reset during data phase");
    data_wait_cfg = 10;
    apply_stimulus(1'b0, 25'h0000300, 32'h0);
    apply_stimulus(1'b0, 25'h0000304, 32'h0);
    apply_stimulus(1'b0, 25'h0000308, 32'h0);
    guard = 0;
    while (!dp_active && guard < 100) begin
      @(negedge HCLK);
      guard++;
    end
    if (!dp_active) record_fail("data_phase_wait");
    HRESET = 1'b1;
    #1;
    check_output("midreset_bus", 64'({HTRANS, HADDR, HWRITE, HSEL}), 64'(0));
    check_output("midreset_data", 64'({HWDATA, rsp_rdata}), 64'(0));
    check_output("midreset_flags", 64'({rsp_valid, rsp_write, rsp_err, req_ready}), 64'(4'b0001));
    rsp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    data_wait_cfg = 0;
    repeat (20) @(negedge HCLK);
    check_output("post_reset_quiet", 64'({HTRANS, rsp_valid, req_ready}), 64'(4'b0001));

    $display("[TB] randomized traffic");
    addr_wait_cfg = -1; data_wait_cfg = -1; rsp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [24:0] a;
      if ($urandom_range(0, 7) == 0) a = ERR_BASE + {9'd0, 14'($urandom), 2'b00};
      else a = {15'd0, 8'($urandom), 2'b00};
      apply_stimulus(1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge HCLK);
    end
    wait_drain("drain_random");
    rsp_mode = 1;
    repeat (5) @(negedge HCLK);
    check_output("final_idle", 64'({HTRANS, rsp_valid, req_ready}), 64'(4'b0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
